// File: rtl/bcd_display_feeder.sv
// bcd_display_feeder: sequential binary-to-packed-BCD converter that feeds a
// 4-digit 7-segment display driver.
//
// A value is accepted over a valid/ready handshake while idle. It is saturated
// to 9999 if it is larger, and then converted with shift-add-3 (double
// dabble), one bit per clock. The registered outputs number, digit_enables and
// overflow are updated together in a single LOAD cycle. This means the display
// never shows a partially converted value.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   defined   - leading zero digits are blanked through digit_enables; the
//               units digit is always enabled.
//   undefined - digit_enables is constant 4'b1111 and no blanking logic exists.
module bcd_display_feeder #(
  parameter int WIDTH = 14  // legal range 4..16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [15:0]      number,
  output logic [3:0]       digit_enables
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic [15:0]        number_q, number_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               too_big;
  logic [15:0]        bcd_corr;

  // Saturation check. A value of at most 13 bits can never exceed 9999, so
  // for narrow widths the comparator is not built at all.
  if (WIDTH >= 14) begin : g_sat
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(9999);
    assign too_big = (in_data > MAX_VAL);
  end else begin : g_nosat
    assign too_big = 1'b0;
  end

  // Add-3 correction for each BCD nibble that is >= 5. The result is at most
  // 12, so the 4-bit add never carries into the next nibble.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bcd_corr[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] digit_en_q, digit_en_d;
  logic [3:0] blank_en;

  // Leading-zero blanking. A digit is lit if it is non-zero or if any more
  // significant digit is lit. The units digit is always lit.
  always_comb begin
    blank_en[3] = (bcd_q[15:12] != 4'd0);
    blank_en[2] = (bcd_q[11:8]  != 4'd0) | blank_en[3];
    blank_en[1] = (bcd_q[7:4]   != 4'd0) | blank_en[2];
    blank_en[0] = 1'b1;
  end
`endif

  // Next-state and datapath logic for the IDLE -> SHIFT -> LOAD sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case, so a path that does
    // not assign it cannot infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    ovf_flag_d = ovf_flag_q;
    number_d   = number_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    digit_en_d = digit_en_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_d      = 16'h0000;
          bin_d      = too_big ? WIDTH'(9999) : in_data;
          ovf_flag_d = too_big;
          cnt_d      = CNT_W'(WIDTH - 1);
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        {bcd_d, bin_d} = {bcd_corr[14:0], bin_q, 1'b0};
        if (cnt_q == '0) begin
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      LOAD: begin
        number_d   = bcd_q;
        overflow_d = ovf_flag_q;
        done_d     = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        digit_en_d = blank_en;
`endif
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset aborts any conversion in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bcd_q      <= '0;
      bin_q      <= '0;
      ovf_flag_q <= 1'b0;
      number_q   <= 16'h0000;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      digit_en_q <= 4'b0001;
`endif
    end else begin
      // NOTE: non-blocking assignments make all flops update together from
      // their pre-edge values, whatever the statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      ovf_flag_q <= ovf_flag_d;
      number_q   <= number_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
`ifdef LEADING_ZERO_BLANK_EN
      digit_en_q <= digit_en_d;
`endif
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign number   = number_q;
`ifdef LEADING_ZERO_BLANK_EN
  assign digit_enables = digit_en_q;
`else
  assign digit_enables = 4'b1111;
`endif

endmodule
